// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared size encodings, FSM state type and lane geometry for the MEM-stage controller.
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int LANES = 4;
  localparam int LANE_AW = 9;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction
endpackage

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: big-endian offset/size to lane mask, store byte placement and load extension.
module mem_lane_mux
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] lane_wdata,
  output logic [31:0] ld_data
);
  logic [1:0] bl;
  logic [1:0] hl;
  logic [7:0] b;
  logic [15:0] h;
  // Offset o lives in lane 3-o, which in two bits is simply ~o.
  assign bl = ~off;
  assign hl = {~off[1], 1'b0};
  always_comb begin
    b = 8'(rdata >> {bl, 3'b000});
    h = 16'(rdata >> {hl[1], 4'b0000});
    mask = size == SZ_BYTE ? 4'b0001 << bl : size == SZ_HALF ? 4'b0011 << hl : 4'b1111;
    lane_wdata = size == SZ_BYTE ? {24'b0, wdata[7:0]} << {bl, 3'b000} :
                 size == SZ_HALF ? {16'b0, wdata[15:0]} << {hl[1], 4'b0000} : wdata;
    ld_data = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
              size == SZ_HALF ? {{16{~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage load/store controller driving four byte lanes.
// DATA_MEM_ALIGN_CHECK_EN turns misaligned half/word accesses into error responses.
module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [10:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [LANES-1:0]    lane_rd_en,
  output logic [LANES-1:0]    lane_wr_en,
  output logic [LANE_AW-1:0]  lane_addr,
  output logic [31:0]         lane_wdata,
  input  logic [31:0]         lane_rdata,
  input  logic [LANES-1:0]    lane_valid
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic we_q, uns_q, err_q, bad, done_ok, timeout;
  logic [1:0] size_q, off_m;
  logic [10:0] addr_q;
  logic [31:0] wdata_q, dbuf, rdata_q, cur, ld_data, mux_wdata;
  logic [3:0] mask, seen, acc;
  logic [CW-1:0] cnt;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign bad = req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0]) ||
               (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  assign bad = req_size == 2'b11;
`endif
  assign off_m = req_size == SZ_WORD ? 2'b00 : req_size == SZ_HALF ? {req_addr[1], 1'b0} : req_addr[1:0];
  // Lanes may answer in different cycles, so bytes already seen are held in dbuf.
  assign acc = seen | (lane_valid & mask);
  assign cur = (lane_rdata & byte_mask(lane_valid & mask)) | (dbuf & ~byte_mask(lane_valid & mask));
  assign done_ok = acc == mask;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  mem_lane_mux u_mux (
    .size(size_q), .off(addr_q[1:0]), .uns(uns_q), .wdata(wdata_q), .rdata(cur),
    .mask(mask), .lane_wdata(mux_wdata), .ld_data(ld_data)
  );
  always_comb begin
    state_n = state;
    req_ready = state == IDLE;
    resp_valid = state == DONE;
    resp_err = state == DONE && err_q;
    resp_rdata = state == DONE ? rdata_q : 32'b0;
    lane_rd_en = state == ISSUE && !we_q ? mask : 4'b0;
    lane_wr_en = state == ISSUE && we_q ? mask : 4'b0;
    lane_addr = state == ISSUE ? addr_q[10:2] : '0;
    lane_wdata = state == ISSUE && we_q ? mux_wdata : 32'b0;
    unique case (state)
      IDLE: state_n = req_valid ? (bad ? DONE : ISSUE) : IDLE;
      ISSUE: state_n = WAIT;
      WAIT: state_n = done_ok || timeout ? DONE : WAIT;
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {we_q, uns_q, err_q, size_q, addr_q, wdata_q} <= '0;
      {dbuf, rdata_q, seen, cnt} <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        we_q <= req_we;
        size_q <= req_size;
        uns_q <= req_unsigned;
        addr_q <= {req_addr[10:2], off_m};
        wdata_q <= req_wdata;
        err_q <= bad;
        {dbuf, rdata_q, seen, cnt} <= '0;
      end
      if (state == WAIT) begin
        seen <= acc;
        dbuf <= cur;
        cnt <= cnt + 1'b1;
        if (done_ok) rdata_q <= we_q ? 32'b0 : ld_data;
        else if (timeout) err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed load/store vectors against a four-lane byte memory model.
module tb_data_mem_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [10:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, lane_wdata, lane_rdata;
  logic [3:0] lane_rd_en, lane_wr_en, lane_valid;
  logic [8:0] lane_addr;
  logic lv_en = 1;
  logic [7:0] mem [4][512];
  int n_assert = 0, n_fail = 0;

  data_mem_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .lane_rd_en(lane_rd_en), .lane_wr_en(lane_wr_en), .lane_addr(lane_addr),
    .lane_wdata(lane_wdata), .lane_rdata(lane_rdata), .lane_valid(lane_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_wr_en[k]) mem[k][lane_addr] <= lane_wdata[8*k +: 8];
      if (lane_rd_en[k]) lane_rdata[8*k +: 8] <= mem[k][lane_addr];
    end
    lane_valid <= (lane_rd_en | lane_wr_en) & {4{lv_en}};
  end

  function automatic logic [31:0] bm(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Runs one request from IDLE; lat is the cycle of resp_valid counted from the accept cycle.
  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [10:0] a, input logic [31:0] wd, input logic [3:0] xen,
                        input logic [31:0] xwd, input logic [31:0] xrd, input logic xerr, input int lat);
    int c;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    cyc();
    req_valid = 0;
    c = 1;
    if (lat > 1) begin
      chk({tag, " rd_en"}, 32'(lane_rd_en), we ? 32'd0 : 32'(xen));
      chk({tag, " wr_en"}, 32'(lane_wr_en), we ? 32'(xen) : 32'd0);
      chk({tag, " addr"}, 32'(lane_addr), 32'(a[10:2]));
      if (we) chk({tag, " wdata"}, lane_wdata & bm(xen), xwd);
    end else begin
      chk({tag, " no_en"}, 32'({lane_rd_en, lane_wr_en}), 32'd0);
    end
    while (!resp_valid && c < 40) begin
      cyc();
      c++;
    end
    chk({tag, " latency"}, 32'(c), 32'(lat));
    chk({tag, " rdata"}, resp_rdata, xrd);
    chk({tag, " err"}, 32'(resp_err), 32'(xerr));
    cyc();
    chk({tag, " idle"}, 32'({req_ready, resp_valid}), 32'b10);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) for (int i = 0; i < 512; i++) mem[k][i] = 8'h00;
    lane_rdata = 0;
    lane_valid = 0;
    cyc();
    cyc();
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset resp", {29'b0, resp_valid, resp_err, 1'b0}, 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    chk("reset lanes", {15'b0, lane_rd_en, lane_wr_en, lane_addr}, 32'd0);
    chk("reset lwdata", lane_wdata, 32'd0);
    rst = 0;
    cyc();
    access("sw 010", 1, 2'b10, 0, 11'h010, 32'h12345678, 4'b1111, 32'h12345678, 32'h0, 0, 3);
    access("lw 010", 0, 2'b10, 0, 11'h010, 32'h0, 4'b1111, 32'h0, 32'h12345678, 0, 3);
    access("sb 021", 1, 2'b00, 0, 11'h021, 32'hAAAAAA80, 4'b0100, 32'h00800000, 32'h0, 0, 3);
    access("lb 021", 0, 2'b00, 0, 11'h021, 32'h0, 4'b0100, 32'h0, 32'hFFFFFF80, 0, 3);
    access("lbu 021", 0, 2'b00, 1, 11'h021, 32'h0, 4'b0100, 32'h0, 32'h00000080, 0, 3);
    access("sh 032", 1, 2'b01, 0, 11'h032, 32'h5555BEEF, 4'b0011, 32'h0000BEEF, 32'h0, 0, 3);
    access("lh 032", 0, 2'b01, 0, 11'h032, 32'h0, 4'b0011, 32'h0, 32'hFFFFBEEF, 0, 3);
    access("lhu 032", 0, 2'b01, 1, 11'h032, 32'h0, 4'b0011, 32'h0, 32'h0000BEEF, 0, 3);
    access("lb 010", 0, 2'b00, 0, 11'h010, 32'h0, 4'b1000, 32'h0, 32'h00000012, 0, 3);
    access("lh 012", 0, 2'b01, 0, 11'h012, 32'h0, 4'b0011, 32'h0, 32'h00005678, 0, 3);
    access("sb 013", 1, 2'b00, 0, 11'h013, 32'h000000FF, 4'b0001, 32'h000000FF, 32'h0, 0, 3);
    access("lb 013", 0, 2'b00, 0, 11'h013, 32'h0, 4'b0001, 32'h0, 32'hFFFFFFFF, 0, 3);
    access("lw 010b", 0, 2'b10, 1, 11'h010, 32'h0, 4'b1111, 32'h0, 32'h123456FF, 0, 3);
    access("sw 040", 1, 2'b10, 0, 11'h040, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0, 0, 3);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    access("lw 041", 0, 2'b10, 0, 11'h041, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1);
    access("lh 011", 0, 2'b01, 0, 11'h011, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1);
`else
    access("lw 041", 0, 2'b10, 0, 11'h041, 32'h0, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 3);
    access("lh 011", 0, 2'b01, 0, 11'h011, 32'h0, 4'b1100, 32'h0, 32'h00001234, 0, 3);
`endif
    access("rsvd size", 0, 2'b11, 0, 11'h010, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1);
    lv_en = 0;
    access("timeout", 0, 2'b10, 0, 11'h010, 32'h0, 4'b1111, 32'h0, 32'h0, 1, 17);
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 11'h010;
    cyc();
    req_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("rst wait ready", 32'(req_ready), 32'd1);
    chk("rst wait resp", 32'(resp_valid), 32'd0);
    chk("rst wait en", 32'({lane_rd_en, lane_wr_en}), 32'd0);
    cyc();
    chk("rst wait resp2", 32'(resp_valid), 32'd0);
    lv_en = 1;
    access("lw after rst", 0, 2'b10, 0, 11'h010, 32'h0, 4'b1111, 32'h0, 32'h123456FF, 0, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

MEM-stage access controller for the MIPS pipeline. Sits between the EX/MEM pipeline register and the four 8-bit data-memory byte lanes (lane k holds bits [8k+7:8k] of each word). Converts one load/store request into per-lane read/write enables, addresses and byte data. Collects the lane responses and returns a sign- or zero-extended 32-bit result with a one-cycle valid pulse.

## Interface
- Parameters: TIMEOUT, default 15, maximum number of WAIT cycles before the access is aborted with an error.
- Reset: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: zero-extend (lbu/lhu)
- req_addr  in  11  byte address; [10:2] word index, [1:0] offset o
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid
- lane_rd_en  out  4  per-lane read enable
- lane_wr_en  out  4  per-lane write enable
- lane_addr  out  9  drives both rd_addr and wr_addr of every lane
- lane_wdata  out  32  byte k drives the data_in of lane k
- lane_rdata  in  32  byte k comes from the data_out of lane k
- lane_valid  in  4  valid_out of each lane

## Operation
- Byte order is big-endian: the byte at offset o lives in lane 3-o.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On req_valid && req_ready, the controller registers the request and computes an expected lane mask M.
  - Byte: M = lane 3-o.
  - Half: M = lanes 3-o and 2-o.
  - Word: M = 4'b1111.
  - Next state is ISSUE, or DONE with err for an error (reserved size, or misalignment; see Configuration).
- **ISSUE** (exactly one cycle)
  - Loads assert lane_rd_en = M; stores assert lane_wr_en = M. The other enable vector is 0.
  - lane_addr = req_addr[10:2].
  - Store data placement:
    - sb: wdata[7:0] goes to lane 3-o.
    - sh: wdata[15:8] goes to lane 3-o and wdata[7:0] to lane 2-o.
    - sw: lane k gets wdata[8k+7:8k].
  - Next state is WAIT.
- **WAIT**
  - Each cycle, lane_valid & M is accumulated into a seen mask.
  - When seen == M, the controller assembles the read data and goes to DONE.
  - A wait counter increments each cycle. When it reaches TIMEOUT, the controller goes to DONE with err.
- **DONE**
  - resp_valid = 1 for one cycle, then IDLE.
- Load assembly:
  - Byte: {24 × ext, b}.
  - Half: {16 × ext, hi, lo}.
  - ext = 0 if req_unsigned, else the MSB of the loaded value.
  - req_unsigned is ignored for word accesses and for stores.
- Stores return resp_rdata = 0, resp_err = 0.

## Timing
- Reset values:
  - state = IDLE, req_ready = 1.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - lane_rd_en = 0, lane_wr_en = 0, lane_addr = 0, lane_wdata = 0.
  - Wait counter = 0, seen = 0.
- Lanes have 1-cycle latency. With request accepted at cycle 0:
  - ISSUE in cycle 1.
  - lane_valid seen in cycle 2 (WAIT).
  - resp_valid in cycle 3.
  - req_ready high again in cycle 4.
- Error response: accept at 0, resp_valid with resp_err in cycle 1. No lane enables are asserted.
- Enables are asserted only in ISSUE and are never held longer than 1 cycle.
- Requests are ignored while req_ready = 0; the upstream holds them.
- Reset mid-operation: the controller returns to IDLE next cycle with all enables dropped and no resp_valid.
  - A lane write sampled before reset is committed; the lanes have no reset.
- Timeout: resp_err = 1 and resp_rdata = 0. lane_valid bits arriving later are ignored.

## Configuration
- `DATA_MEM_ALIGN_CHECK_EN`
  - Defined: half with o[0] = 1, or word with o ≠ 0, is an error response. No memory access occurs.
  - Undefined: the low offset bits are masked (half clears o[0], word forces o = 0) and the access proceeds normally.
  - The reserved size is an error in both builds.

## Structure
- Package `mips_mem_pkg` holds:
  - Size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state typedef.
  - Lane count (4) and lane address width (9).
- One natural sub-module: `mem_lane_mux`. It is combinational and does offset/size → lane mask, store-data placement and load assembly/extension.
- The FSM and counters stay in the top module.

## Test plan
- sw addr 0x010, data 0x12345678, then lw 0x010 → lane_wr_en = 1111, lane_addr = 4; load returns 0x12345678 at cycle 3 after accept.
- sb 0x021, data 0x80, then lb 0x021 / lbu 0x021 → only lane 2 written; responses 0xFFFFFF80 / 0x00000080.
- sh 0x032, data 0xBEEF, then lh / lhu 0x032 → lanes 1,0 written; responses 0xFFFFBEEF / 0x0000BEEF.
- lw 0x041 with the macro defined → resp_err = 1 at cycle 1 with no enables. Without the macro → word at 0x040 is read.
- Hold lane_valid = 0 after a load → resp_err = 1 after TIMEOUT WAIT cycles, resp_rdata = 0.
- rst in WAIT → next cycle IDLE, req_ready = 1, no resp_valid. A following lw completes normally.
